cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Sequences one-frame or continuous capture from the OV-style camera port (PCLK/HREF/VSYNC, RGB565 as two bytes per pixel) into the 160x120 frame buffer.
- Samples the camera pins in the system clock domain and assembles byte pairs into RGB444 pixels.
- Generates buffer write address, data and enable.
- Reports busy, done and frame error to the top-level test_cam glue.

Parameters:
- IMG_W, 160, pixels per line accepted.
- IMG_H, 120, lines per frame accepted.
- AW, 15, buffer address width (IMG_W*IMG_H <= 2**AW).

Ports:
- clk  in  1  system clock; frequency must be >= 4x CAM_PCLK.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle capture request.
- abort  in  1  one-cycle abort request.
- continuous  in  1  1 = re-arm automatically after each frame; sampled at start.
- CAM_PCLK  in  1  camera pixel clock, asynchronous to clk.
- CAM_HREF  in  1  line valid, camera domain.
- CAM_VSYNC  in  1  frame sync, camera domain; high during vertical blank start.
- CAM_px_data  in  8  camera byte.
- mem_addr  out  AW  buffer write address.
- mem_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- mem_we  out  1  buffer write strobe, one clk per pixel.
- busy  out  1  capture in progress.
- done  out  1  one-clk pulse at end of frame.
- frame_err  out  1  sticky error flag; cleared on accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, frame_err=0; synchronizers, counters and byte phase cleared.
- Input sync: CAM_PCLK, CAM_HREF, CAM_VSYNC each pass through 2 FF. CAM_px_data passes through 2 FF aligned with PCLK.
- Edge strobes: pclk_rise, href_fall, vs_rise and vs_fall are one-clk strobes from the synchronized signals, registered one more stage. Each strobe is high 3 clk after the pin edge.
- Pixel assembly: on pclk_rise with synced HREF=1, byte_phase toggles.
  - Phase 0 stores the high byte.
  - Phase 1 forms p={hi,lo} and mem_data = {p[15:12], p[10:7], p[4:1]}.
- Write strobe: mem_we is high for exactly the clk after the phase-1 pclk_rise, if col<IMG_W and row<IMG_H. mem_addr = row_base + col on that cycle; col then increments.
- Suppressed writes (col>=IMG_W or row>=IMG_H): no mem_we, frame_err set.
- Line end (href_fall in CAPTURE):
  - byte_phase=1 sets frame_err.
  - byte_phase and col clear.
  - row increments and row_base += IMG_W, both saturating at IMG_H.
- States:
  - IDLE: busy=0. An accepted start clears frame_err, latches continuous and goes to ARM.
  - ARM: wait for synced VSYNC=1, so a start issued mid-frame never captures a partial frame; then go to WAIT_FRAME.
  - WAIT_FRAME: on vs_fall, clear row, col, row_base and byte_phase, and go to CAPTURE.
  - CAPTURE: on vs_rise, set frame_err if row!=IMG_H (short frame), pulse done one clk, then go to WAIT_FRAME if continuous, else IDLE.
- busy=1 in ARM, WAIT_FRAME and CAPTURE.
- start while busy: ignored.
- abort in any state: go to IDLE next clk with no done pulse; a write already registered completes. abort and start in the same cycle: abort wins.
- The last frame write and vs_rise cannot coincide, given blanking; if they do, the write is issued before done.

Test Plan:
- Nominal frame: bench timing (PCLK = clk/4, 320+4 bytes/line, 120+4 lines), bytes 0xE0,0x1F, start with continuous=0. Required: 19200 mem_we pulses, first addr 0, last addr 19199, mem_data=0xE0F, one done pulse, frame_err=0, busy falls with done.
- start asserted while VSYNC=0 mid-frame: no mem_we until the next VSYNC high-then-low; then a full 19200-write frame.
- One line carrying 322 bytes (161 px): 160 writes on that line, 161st suppressed, frame_err=1, next line starts at row_base+160.
- One line carrying 319 bytes: frame_err=1 at href_fall, next line's first write has col=0 and correct byte pairing.
- continuous=1 over two frames: two done pulses; second frame's first write at addr 0; busy stays 1; abort then gives busy=0 with no further writes.
- rst=0 mid-CAPTURE: all outputs 0 immediately, without waiting for clk. After release, a start-driven capture completes with 19200 writes and frame_err=0.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cam_capture_ctrl
// Function : OV-style camera (RGB565 byte pairs) capture into an RGB444 frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          continuous,
    input  logic          CAM_PCLK,
    input  logic          CAM_HREF,
    input  logic          CAM_VSYNC,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] mem_addr,
    output logic [11:0]   mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          frame_err
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] c_col_max  = CW'(IMG_W);
    localparam logic [RW-1:0] c_row_max  = RW'(IMG_H);
    localparam logic [AW-1:0] c_row_step = AW'(IMG_W);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_cap  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_next;

    logic [1:0]    r_pclk_s;
    logic [1:0]    r_href_s;
    logic [1:0]    r_vs_s;
    logic [7:0]    r_data_s1;
    logic [7:0]    r_data_s2;
    logic          r_pclk_d;
    logic          r_href_d;
    logic          r_vs_d;
    logic [7:0]    r_data_q;
    logic          r_pclk_rise;
    logic          r_href_fall;
    logic          r_vs_rise;
    logic          r_vs_fall;

    logic          r_cont;
    logic          r_phase;
    logic [6:0]    r_hi;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_row_base;

    logic          w_accept;
    logic          w_capturing;

    // Two-flop synchronizers, then one edge-detect stage; r_href_d and r_data_q
    // share the age of the strobes so a strobe sees the byte it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pclk_s    <= '0;
            r_href_s    <= '0;
            r_vs_s      <= '0;
            r_data_s1   <= '0;
            r_data_s2   <= '0;
            r_pclk_d    <= 1'b0;
            r_href_d    <= 1'b0;
            r_vs_d      <= 1'b0;
            r_data_q    <= '0;
            r_pclk_rise <= 1'b0;
            r_href_fall <= 1'b0;
            r_vs_rise   <= 1'b0;
            r_vs_fall   <= 1'b0;
        end else begin
            r_pclk_s    <= {r_pclk_s[0], CAM_PCLK};
            r_href_s    <= {r_href_s[0], CAM_HREF};
            r_vs_s      <= {r_vs_s[0], CAM_VSYNC};
            r_data_s1   <= CAM_px_data;
            r_data_s2   <= r_data_s1;
            r_pclk_d    <= r_pclk_s[1];
            r_href_d    <= r_href_s[1];
            r_vs_d      <= r_vs_s[1];
            r_data_q    <= r_data_s2;
            r_pclk_rise <= r_pclk_s[1] & ~r_pclk_d;
            r_href_fall <= ~r_href_s[1] & r_href_d;
            r_vs_rise   <= r_vs_s[1] & ~r_vs_d;
            r_vs_fall   <= ~r_vs_s[1] & r_vs_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (start)        w_next = c_st_arm;
                c_st_arm:  if (r_vs_s[1])    w_next = c_st_wait;
                c_st_wait: if (r_vs_fall)    w_next = c_st_cap;
                c_st_cap:  if (r_vs_rise)    w_next = r_cont ? c_st_wait : c_st_idle;
                default:                     w_next = c_st_idle;
            endcase
        end
    end

    always_comb begin
        busy        = (r_state != c_st_idle);
        w_accept    = (r_state == c_st_idle) && start && !abort;
        w_capturing = (r_state == c_st_cap) && !abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            r_cont     <= 1'b0;
            r_phase    <= 1'b0;
            r_hi       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;

            if (w_accept) begin
                frame_err <= 1'b0;
                r_cont    <= continuous;
            end

            if ((r_state == c_st_wait) && r_vs_fall && !abort) begin
                r_phase    <= 1'b0;
                r_col      <= '0;
                r_row      <= '0;
                r_row_base <= '0;
            end

            if (w_capturing) begin
                // Only the RGB444-relevant bits of the high byte are kept.
                if (r_pclk_rise && r_href_d) begin
                    if (!r_phase) begin
                        r_hi    <= {r_data_q[7:4], r_data_q[2:0]};
                        r_phase <= 1'b1;
                    end else begin
                        r_phase  <= 1'b0;
                        mem_data <= {r_hi[6:3], r_hi[2:0], r_data_q[7], r_data_q[4:1]};
                        if ((r_col < c_col_max) && (r_row < c_row_max)) begin
                            mem_we   <= 1'b1;
                            mem_addr <= r_row_base + AW'(r_col);
                            r_col    <= r_col + 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                if (r_href_fall) begin
                    if (r_phase) begin
                        frame_err <= 1'b1;
                    end
                    r_phase <= 1'b0;
                    r_col   <= '0;
                    if (r_row < c_row_max) begin
                        r_row      <= r_row + 1'b1;
                        r_row_base <= r_row_base + c_row_step;
                    end
                end

                // A write landing on this same cycle is still issued with done.
                if (r_vs_rise) begin
                    if (r_row != c_row_max) begin
                        frame_err <= 1'b1;
                    end
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture_ctrl
// Function : Scoreboard bench for cam_capture_ctrl on a reduced 16x8 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_ctrl;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 15;
    localparam int LB = 2 * W + 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          continuous;
    logic          CAM_PCLK;
    logic          CAM_HREF;
    logic          CAM_VSYNC;
    logic [7:0]    CAM_px_data;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          frame_err;

    cam_capture_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .CAM_PCLK    (CAM_PCLK),
        .CAM_HREF    (CAM_HREF),
        .CAM_VSYNC   (CAM_VSYNC),
        .CAM_px_data (CAM_px_data),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .frame_err   (frame_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    typedef struct packed {
        logic err;
        logic busy;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per presented write / done pulse.
    always @(negedge clk) begin : mon
        wr_t we;
        dn_t de;
        if (rst === 1'b1) begin
            if (mem_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_data);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(we.addr));
                    check("wr_data", 32'(mem_data), 32'(we.data));
                end
            end
            if (done === 1'b1) begin
                if (dn_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    de = dn_q.pop_front();
                    check("done_err", 32'(frame_err), 32'(de.err));
                    check("done_busy", 32'(busy), 32'(de.busy));
                end
            end
        end
    end

    function automatic logic [7:0] byte_at(input int pat, input int r, input int j);
        if (pat == 0) return (j % 2 == 0) ? 8'hE0 : 8'h1F;
        return 8'((r * 37 + j * 11 + 5) % 256);
    endfunction

    function automatic logic [11:0] pix(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] p;
        p = {hi, lo};
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    // One camera byte period: pins change on PCLK fall, sampled on PCLK rise.
    task automatic cam_cycle(input logic href, input logic vs, input logic [7:0] d);
        CAM_PCLK    = 1'b0;
        CAM_HREF    = href;
        CAM_VSYNC   = vs;
        CAM_px_data = d;
        #20;
        CAM_PCLK    = 1'b1;
        #20;
    endtask

    task automatic send_frame(input int sp_line, input int sp_bytes, input int pat,
                              input bit cap, input bit exp_err, input bit exp_busy,
                              input int stop_after);
        int nb;
        logic [11:0] px;
        repeat (LB) cam_cycle(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < H; r++) begin
            if (r == stop_after) return;
            nb = (r == sp_line) ? sp_bytes : 2 * W;
            if (cap) begin
                for (int k = 0; k < nb / 2 && k < W; k++) begin
                    px = (pat == 0) ? 12'hE0F : pix(byte_at(pat, r, 2 * k), byte_at(pat, r, 2 * k + 1));
                    wr_q.push_back(wr_t'{AW'(r * W + k), px});
                end
            end
            for (int j = 0; j < nb; j++) cam_cycle(1'b1, 1'b0, byte_at(pat, r, j));
            repeat (4) cam_cycle(1'b0, 1'b0, 8'h00);
            if (cap && r == sp_line) check("line_err", 32'(frame_err), 32'd1);
        end
        if (cap) dn_q.push_back(dn_t'{exp_err, exp_busy});
        repeat (4 * LB) cam_cycle(1'b0, 1'b1, 8'h00);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: got no finish expected finish within 2 ms");
        summary();
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        continuous  = 1'b0;
        CAM_PCLK    = 1'b0;
        CAM_HREF    = 1'b0;
        CAM_VSYNC   = 1'b1;
        CAM_px_data = 8'h00;
        #1 rst = 1'b0;
        #1;
        check("reset_state", {15'b0, mem_addr, mem_data, mem_we, busy, done, frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Nominal single frame, fixed E0/1F bytes.
        pulse_start();
        check("busy_armed", 32'(busy), 32'd1);
        send_frame(-1, 0, 0, 1'b1, 1'b0, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_err", 32'(frame_err), 32'd0);

        // Start issued mid-frame: that frame is skipped, the next one captured.
        fork
            send_frame(-1, 0, 1, 1'b0, 1'b0, 1'b0, -1);
            begin
                #(LB * 40 * 3);
                pulse_start();
            end
        join
        check("armed_busy", 32'(busy), 32'd1);
        send_frame(-1, 0, 1, 1'b1, 1'b0, 1'b0, -1);

        // Over-long line: 17th pixel suppressed.
        pulse_start();
        send_frame(2, 2 * W + 2, 1, 1'b1, 1'b1, 1'b0, -1);
        #1;
        check("err_sticky", 32'(frame_err), 32'd1);

        // Odd-length line: dangling byte flagged, next line pairs cleanly.
        pulse_start();
        check("err_clear", 32'(frame_err), 32'd0);
        send_frame(3, 2 * W - 1, 1, 1'b1, 1'b1, 1'b0, -1);

        // Continuous over two frames, then abort.
        continuous = 1'b1;
        pulse_start();
        continuous = 1'b0;
        send_frame(-1, 0, 0, 1'b1, 1'b0, 1'b1, -1);
        check("cont_busy1", 32'(busy), 32'd1);
        send_frame(-1, 0, 1, 1'b1, 1'b0, 1'b1, -1);
        check("cont_busy2", 32'(busy), 32'd1);
        pulse_abort();
        check("abort_busy", 32'(busy), 32'd0);
        send_frame(-1, 0, 1, 1'b0, 1'b0, 1'b0, -1);

        // Asynchronous reset in the middle of a capture.
        pulse_start();
        send_frame(-1, 0, 1, 1'b1, 1'b0, 1'b0, 3);
        repeat (8) @(posedge clk);
        check("drain", 32'(wr_q.size()), 32'd0);
        #3 rst = 1'b0;
        #1;
        check("async_reset", {15'b0, mem_addr, mem_data, mem_we, busy, done, frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4 * LB) cam_cycle(1'b0, 1'b1, 8'h00);
        pulse_start();
        send_frame(-1, 0, 0, 1'b1, 1'b0, 1'b0, -1);

        repeat (20) @(posedge clk);
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("done_left", 32'(dn_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
